// File: rtl/bx0_match_chk_pkg.sv
// Shared definitions for the bx0 match checker: compare-FSM state encodings and default widths.
package bx0_match_chk_pkg;

  localparam int MXDLY = 4;   // alct_bx0_delay width, delay line depth 2**MXDLY-1
  localparam int MXWIN = 3;   // match_win width
  localparam int MXCNT = 16;  // optional mismatch counter width

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_CLCT = 2'd1,
    WAIT_ALCT = 2'd2
  } bx0_state_t;

endpackage

// File: rtl/bx0_match_chk_if.sv
// Control/marker/result bundle between the bx0 sources, VME registers and the match checker.
interface bx0_match_chk_if;
  import bx0_match_chk_pkg::*;

  logic             ttc_resync;
  logic             bx0_match_en;
  logic             alct_bx0;
  logic             clct_bx0;
  logic [MXDLY-1:0] alct_bx0_delay;
  logic [MXWIN-1:0] match_win;
  logic             bx0_match_err;
  logic             bx0_match_ok;
  logic             bx0_match_last;
  logic             alct_bx0_dly;
  logic [MXCNT-1:0] bx0_mismatch_cnt;

  modport master (
    output ttc_resync, bx0_match_en, alct_bx0, clct_bx0, alct_bx0_delay, match_win,
    input  bx0_match_err, bx0_match_ok, bx0_match_last, alct_bx0_dly, bx0_mismatch_cnt
  );

  modport slave (
    input  ttc_resync, bx0_match_en, alct_bx0, clct_bx0, alct_bx0_delay, match_win,
    output bx0_match_err, bx0_match_ok, bx0_match_last, alct_bx0_dly, bx0_mismatch_cnt
  );

endinterface

// File: rtl/bx0_dly_line.sv
// Programmable marker delay: shift register with a tap mux; tap 0 passes the input through.
module bx0_dly_line #(
  parameter int MXDLY = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             din,
  input  logic [MXDLY-1:0] dly,
  output logic             dout
);

  localparam int DEPTH = (1 << MXDLY) - 1;

  logic [DEPTH-1:0] srl;
  logic [DEPTH:0]   taps;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) srl <= '0;
    else          srl <= {srl[DEPTH-2:0], din};
  end

  // Tap select is live: changing dly re-points the output without flushing.
  assign taps = {srl, din};
  assign dout = taps[dly];

endmodule

// File: rtl/bx0_match_chk.sv
// Orbit bx0 alignment check between delayed ALCT and CLCT markers; pulses ok/err per comparison.
// Optional saturating mismatch counter enabled by defining BX0_MISMATCH_CNT_EN.
module bx0_match_chk
  import bx0_match_chk_pkg::*;
(
  input logic            clock,
  input logic            reset_n,
  bx0_match_chk_if.slave bus
);

  logic             a_dly;
  logic             c_mk;
  bx0_state_t       state, state_n;
  logic [MXWIN-1:0] win_cnt, win_n;
  logic             ok_n, err_n;
  logic             ok_q, err_q, last_q;

  bx0_dly_line #(.MXDLY(MXDLY)) u_alct_dly (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (bus.alct_bx0),
    .dly     (bus.alct_bx0_delay),
    .dout    (a_dly)
  );

  assign c_mk = bus.clct_bx0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      win_cnt <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_n;
      win_cnt <= win_n;
      ok_q    <= ok_n;
      err_q   <= err_n;
      if (bus.ttc_resync) last_q <= 1'b0;
      else if (ok_n)      last_q <= 1'b1;
      else if (err_n)     last_q <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    win_n   = win_cnt;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    if (bus.ttc_resync || !bus.bx0_match_en) begin
      state_n = IDLE;
      win_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_dly && c_mk) begin
            ok_n = 1'b1;
          end else if (a_dly || c_mk) begin
            if (bus.match_win == '0) begin
              err_n = 1'b1;
            end else begin
              state_n = a_dly ? WAIT_CLCT : WAIT_ALCT;
              win_n   = MXWIN'(1);
            end
          end
        end
        WAIT_CLCT, WAIT_ALCT: begin
          // Partner takes priority; a coincident same-source marker opens a fresh window.
          if ((state == WAIT_CLCT) ? c_mk : a_dly) begin
            ok_n = 1'b1;
            if (a_dly && c_mk) begin
              win_n = MXWIN'(1);
            end else begin
              state_n = IDLE;
              win_n   = '0;
            end
          end else if ((state == WAIT_CLCT) ? a_dly : c_mk) begin
            err_n = 1'b1;
            win_n = MXWIN'(1);
          end else if (win_cnt >= bus.match_win) begin
            err_n   = 1'b1;
            state_n = IDLE;
            win_n   = '0;
          end else begin
            win_n = win_cnt + MXWIN'(1);
          end
        end
        default: begin
          state_n = IDLE;
          win_n   = '0;
        end
      endcase
    end
  end

  assign bus.bx0_match_ok   = ok_q;
  assign bus.bx0_match_err  = err_q;
  assign bus.bx0_match_last = last_q;
  assign bus.alct_bx0_dly   = a_dly;

`ifdef BX0_MISMATCH_CNT_EN
  logic [MXCNT-1:0] mis_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    mis_cnt <= '0;
    else if (bus.ttc_resync)         mis_cnt <= '0;
    else if (err_n && mis_cnt != '1) mis_cnt <= mis_cnt + MXCNT'(1);
  end

  assign bus.bx0_mismatch_cnt = mis_cnt;
`else
  assign bus.bx0_mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_bx0_match_chk.sv
// Scoreboard bench for bx0_match_chk: per-cycle expected ok/err queued at drive time, popped after the edge.
module tb_bx0_match_chk;
  import bx0_match_chk_pkg::*;

  typedef struct {
    logic ok;
    logic err;
  } exp_t;

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;
  exp_t exp_q[$];

  bx0_match_chk_if bus();

  bx0_match_chk dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_cycle(input logic a, input logic c);
    bus.alct_bx0 = a;
    bus.clct_bx0 = c;
    @(posedge clock);
    #1;
  endtask

  task automatic setup(input logic [MXDLY-1:0] d, input logic [MXWIN-1:0] w);
    bus.bx0_match_en   = 1'b0;
    bus.alct_bx0_delay = '0;
    repeat (16) run_cycle(1'b0, 1'b0);
    bus.alct_bx0_delay = d;
    bus.match_win      = w;
    bus.bx0_match_en   = 1'b1;
    bus.ttc_resync     = 1'b1;
    run_cycle(1'b0, 1'b0);
    bus.ttc_resync     = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.ttc_resync = 1'b0; bus.bx0_match_en = 1'b0;
    bus.alct_bx0 = 1'b0; bus.clct_bx0 = 1'b0;
    bus.alct_bx0_delay = '0; bus.match_win = '0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({bus.bx0_match_ok, bus.bx0_match_err, bus.bx0_match_last, bus.alct_bx0_dly} !== 4'b0000 ||
        bus.bx0_mismatch_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset: ok/err/last/dly=%b%b%b%b cnt=%0d, expected 0000 cnt=0",
               bus.bx0_match_ok, bus.bx0_match_err, bus.bx0_match_last, bus.alct_bx0_dly,
               bus.bx0_mismatch_cnt);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_delay_match();
    exp_t e;
    setup(4'd3, 3'd0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{ok: (i == 3), err: 1'b0});
      run_cycle(i == 0, i == 3);
      e = exp_q.pop_front();
      vectors++;
      if (bus.bx0_match_ok !== e.ok || bus.bx0_match_err !== e.err || bus.alct_bx0_dly !== (i == 2)) begin
        miscompares++;
        $display("FAIL delay_match i=%0d: ok/err/dly=%b%b%b expected %b%b%b", i,
                 bus.bx0_match_ok, bus.bx0_match_err, bus.alct_bx0_dly, e.ok, e.err, (i == 2));
      end
    end
    vectors++;
    if (bus.bx0_match_last !== 1'b1) begin
      miscompares++;
      $display("FAIL delay_match_last: last=%b expected 1", bus.bx0_match_last);
    end
  endtask

  task automatic test_window();
    exp_t e;
    setup(4'd0, 3'd2);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{ok: (i == 2), err: 1'b0});
      run_cycle(i == 2, i == 0);
      e = exp_q.pop_front();
      vectors++;
      if (bus.bx0_match_ok !== e.ok || bus.bx0_match_err !== e.err) begin
        miscompares++;
        $display("FAIL window_in i=%0d: ok/err=%b%b expected %b%b", i,
                 bus.bx0_match_ok, bus.bx0_match_err, e.ok, e.err);
      end
    end
    setup(4'd0, 3'd2);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{ok: 1'b0, err: (i == 2 || i == 5)});
      run_cycle(i == 3, i == 0);
      e = exp_q.pop_front();
      vectors++;
      if (bus.bx0_match_ok !== e.ok || bus.bx0_match_err !== e.err) begin
        miscompares++;
        $display("FAIL window_late i=%0d: ok/err=%b%b expected %b%b", i,
                 bus.bx0_match_ok, bus.bx0_match_err, e.ok, e.err);
      end
    end
    vectors++;
    if (bus.bx0_match_last !== 1'b0) begin
      miscompares++;
      $display("FAIL window_last: last=%b expected 0", bus.bx0_match_last);
    end
  endtask

  task automatic test_single_err();
    exp_t e;
    logic [MXCNT-1:0] cnt_exp;
    setup(4'd0, 3'd0);
    run_cycle(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{ok: 1'b0, err: (i == 0 || i == 2)});
      run_cycle(i == 0, i == 2);
      e = exp_q.pop_front();
      vectors++;
      if (bus.bx0_match_ok !== e.ok || bus.bx0_match_err !== e.err) begin
        miscompares++;
        $display("FAIL single_err i=%0d: ok/err=%b%b expected %b%b", i,
                 bus.bx0_match_ok, bus.bx0_match_err, e.ok, e.err);
      end
    end
`ifdef BX0_MISMATCH_CNT_EN
    cnt_exp = 16'd2;
`else
    cnt_exp = 16'd0;
`endif
    vectors++;
    if (bus.bx0_match_last !== 1'b0 || bus.bx0_mismatch_cnt !== cnt_exp) begin
      miscompares++;
      $display("FAIL single_err_state: last=%b cnt=%0d expected last=0 cnt=%0d",
               bus.bx0_match_last, bus.bx0_mismatch_cnt, cnt_exp);
    end
  endtask

  task automatic test_repeat_marker();
    exp_t e;
    setup(4'd0, 3'd4);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back('{ok: (i == 5), err: (i == 2)});
      run_cycle(i == 5, i == 0 || i == 2);
      e = exp_q.pop_front();
      vectors++;
      if (bus.bx0_match_ok !== e.ok || bus.bx0_match_err !== e.err) begin
        miscompares++;
        $display("FAIL repeat_marker i=%0d: ok/err=%b%b expected %b%b", i,
                 bus.bx0_match_ok, bus.bx0_match_err, e.ok, e.err);
      end
    end
  endtask

  task automatic test_both_in_wait();
    exp_t e;
    setup(4'd0, 3'd3);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{ok: (i == 2), err: (i == 5)});
      run_cycle(i == 0 || i == 2, i == 2);
      e = exp_q.pop_front();
      vectors++;
      if (bus.bx0_match_ok !== e.ok || bus.bx0_match_err !== e.err) begin
        miscompares++;
        $display("FAIL both_in_wait i=%0d: ok/err=%b%b expected %b%b", i,
                 bus.bx0_match_ok, bus.bx0_match_err, e.ok, e.err);
      end
    end
  endtask

  task automatic test_win_shrink();
    exp_t e;
    setup(4'd0, 3'd5);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) bus.match_win = 3'd1;
      exp_q.push_back('{ok: 1'b0, err: (i == 3)});
      run_cycle(1'b0, i == 0);
      e = exp_q.pop_front();
      vectors++;
      if (bus.bx0_match_ok !== e.ok || bus.bx0_match_err !== e.err) begin
        miscompares++;
        $display("FAIL win_shrink i=%0d: ok/err=%b%b expected %b%b", i,
                 bus.bx0_match_ok, bus.bx0_match_err, e.ok, e.err);
      end
    end
  endtask

  task automatic test_resync();
    exp_t e;
    setup(4'd0, 3'd5);
    run_cycle(1'b1, 1'b1);
    vectors++;
    if (bus.bx0_match_ok !== 1'b1 || bus.bx0_match_last !== 1'b1) begin
      miscompares++;
      $display("FAIL resync_pre: ok/last=%b%b expected 11", bus.bx0_match_ok, bus.bx0_match_last);
    end
    for (int i = 0; i < 10; i++) begin
      bus.ttc_resync = (i == 2);
      exp_q.push_back('{ok: 1'b0, err: 1'b0});
      run_cycle(i == 0, 1'b0);
      e = exp_q.pop_front();
      vectors++;
      if (bus.bx0_match_ok !== e.ok || bus.bx0_match_err !== e.err) begin
        miscompares++;
        $display("FAIL resync i=%0d: ok/err=%b%b expected %b%b", i,
                 bus.bx0_match_ok, bus.bx0_match_err, e.ok, e.err);
      end
    end
    bus.ttc_resync = 1'b0;
    vectors++;
    if (bus.bx0_match_last !== 1'b0 || bus.bx0_mismatch_cnt !== '0) begin
      miscompares++;
      $display("FAIL resync_state: last=%b cnt=%0d expected last=0 cnt=0",
               bus.bx0_match_last, bus.bx0_mismatch_cnt);
    end
  endtask

  task automatic test_enable();
    exp_t e;
    setup(4'd0, 3'd0);
    run_cycle(1'b1, 1'b1);
    bus.bx0_match_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{ok: 1'b0, err: 1'b0});
      run_cycle(i % 3 != 2, i % 3 != 1);
      e = exp_q.pop_front();
      vectors++;
      if (bus.bx0_match_ok !== e.ok || bus.bx0_match_err !== e.err) begin
        miscompares++;
        $display("FAIL enable_off i=%0d: ok/err=%b%b expected %b%b", i,
                 bus.bx0_match_ok, bus.bx0_match_err, e.ok, e.err);
      end
    end
    vectors++;
    if (bus.bx0_match_last !== 1'b1) begin
      miscompares++;
      $display("FAIL enable_last_hold: last=%b expected 1", bus.bx0_match_last);
    end
    bus.bx0_match_en = 1'b1;
  endtask

`ifdef BX0_MISMATCH_CNT_EN
  task automatic test_cnt_saturate();
    setup(4'd0, 3'd0);
    for (int i = 0; i < 65540; i++) run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b0);
    vectors++;
    if (bus.bx0_mismatch_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL cnt_saturate: cnt=%h expected ffff", bus.bx0_mismatch_cnt);
    end
  endtask
`endif

  task automatic test_async_reset();
    setup(4'd0, 3'd0);
    run_cycle(1'b1, 1'b1);
    bus.alct_bx0 = 1'b0;
    bus.clct_bx0 = 1'b0;
    vectors++;
    if (bus.bx0_match_ok !== 1'b1 || bus.bx0_match_last !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset_pre: ok/last=%b%b expected 11", bus.bx0_match_ok, bus.bx0_match_last);
    end
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.bx0_match_ok, bus.bx0_match_err, bus.bx0_match_last} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset: ok/err/last=%b%b%b expected 000",
               bus.bx0_match_ok, bus.bx0_match_err, bus.bx0_match_last);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_delay_match();
    test_window();
    test_single_err();
    test_repeat_marker();
    test_both_in_wait();
    test_win_shrink();
    test_resync();
    test_enable();
`ifdef BX0_MISMATCH_CNT_EN
    test_cnt_saturate();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
